// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide engine: iterative shift-add multiply and restoring divide, MTHI/MTLO writes.
// Optional build macro MULDIV_FAST_MULT_EN: MULT/MULTU complete in one cycle; divide stays iterative.
module hilo_muldiv_unit #(
    parameter int WORD_LEN = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          md_op,
    input  logic [WORD_LEN-1:0] val1,
    input  logic [WORD_LEN-1:0] val2,
    input  logic                mf_req,
    input  logic                flush,
    output logic [WORD_LEN-1:0] hi,
    output logic [WORD_LEN-1:0] lo,
    output logic                busy,
    output logic                done,
    output logic                stall
);
    localparam int CW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [2*WORD_LEN-1:0] acc_q, acc_d;
    logic [WORD_LEN-1:0]   opb_q, opb_d;
    logic [WORD_LEN-1:0]   hi_q, hi_d;
    logic [WORD_LEN-1:0]   lo_q, lo_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  is_div_q, is_div_d;
    logic                  neg_q, neg_d;
    logic                  rem_neg_q, rem_neg_d;
    logic                  divz_q, divz_d;
    logic                  done_q, done_d;

    logic                  sign_a_s, sign_b_s;
    logic [WORD_LEN-1:0]   mag_a_s, mag_b_s;
    logic [WORD_LEN:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [2*WORD_LEN-1:0] step_s, prod_s;
    logic [WORD_LEN-1:0]   quot_s, rem_s;
`ifdef MULDIV_FAST_MULT_EN
    logic [2*WORD_LEN-1:0] fast_prod_s;
`endif

    // Operand conditioning: signed ops (md_op[0]==0) iterate on magnitudes.
    always_comb begin
        sign_a_s = ~md_op[0] & val1[WORD_LEN-1];
        sign_b_s = ~md_op[0] & val2[WORD_LEN-1];
        mag_a_s  = sign_a_s ? (-val1) : val1;
        mag_b_s  = sign_b_s ? (-val2) : val2;
`ifdef MULDIV_FAST_MULT_EN
        fast_prod_s = {{WORD_LEN{sign_a_s}}, val1} * {{WORD_LEN{sign_b_s}}, val2};
`endif
    end

    // One iteration step and final sign correction.
    // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[2*WORD_LEN-1:WORD_LEN]}
                    + (acc_q[0] ? {1'b0, opb_q} : {(WORD_LEN+1){1'b0}});
        div_shift_s = {acc_q[2*WORD_LEN-1:WORD_LEN], acc_q[WORD_LEN-1]};
        div_diff_s  = div_shift_s - {1'b0, opb_q};
        if (is_div_q) begin
            if (div_diff_s[WORD_LEN]) begin
                step_s = {div_shift_s[WORD_LEN-1:0], acc_q[WORD_LEN-2:0], 1'b0};
            end else begin
                step_s = {div_diff_s[WORD_LEN-1:0], acc_q[WORD_LEN-2:0], 1'b1};
            end
        end else begin
            step_s = {mul_sum_s, acc_q[WORD_LEN-1:1]};
        end
        prod_s = neg_q ? (-acc_q) : acc_q;
        // A zero divisor leaves the dividend magnitude as remainder, so only the quotient needs forcing.
        quot_s = divz_q ? {WORD_LEN{1'b1}}
                        : (neg_q ? (-acc_q[WORD_LEN-1:0]) : acc_q[WORD_LEN-1:0]);
        rem_s  = rem_neg_q ? (-acc_q[2*WORD_LEN-1:WORD_LEN]) : acc_q[2*WORD_LEN-1:WORD_LEN];
    end

    // Next-state and register update logic for the IDLE -> CALC -> FIX sequence.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        divz_d    = divz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (md_op)
`ifdef MULDIV_FAST_MULT_EN
                        OP_MULT, OP_MULTU: begin
                            hi_d   = fast_prod_s[2*WORD_LEN-1:WORD_LEN];
                            lo_d   = fast_prod_s[WORD_LEN-1:0];
                            done_d = 1'b1;
                        end
`else
                        OP_MULT, OP_MULTU: begin
                            is_div_d  = 1'b0;
                            neg_d     = sign_a_s ^ sign_b_s;
                            rem_neg_d = 1'b0;
                            divz_d    = 1'b0;
                            acc_d     = {{WORD_LEN{1'b0}}, mag_b_s};
                            opb_d     = mag_a_s;
                            count_d   = CW'(WORD_LEN - 1);
                            state_d   = ST_CALC;
                        end
`endif
                        OP_DIV, OP_DIVU: begin
                            is_div_d  = 1'b1;
                            neg_d     = sign_a_s ^ sign_b_s;
                            rem_neg_d = sign_a_s;
                            divz_d    = (val2 == {WORD_LEN{1'b0}});
                            acc_d     = {{WORD_LEN{1'b0}}, mag_a_s};
                            opb_d     = mag_b_s;
                            count_d   = CW'(WORD_LEN - 1);
                            state_d   = ST_CALC;
                        end
                        OP_MTHI: hi_d = val1;
                        OP_MTLO: lo_d = val1;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_s;
                    if (count_q == {CW{1'b0}}) begin
                        state_d = ST_FIX;
                    end else begin
                        count_d = count_q - CW'(1);
                    end
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (is_div_q) begin
                        hi_d = rem_s;
                        lo_d = quot_s;
                    end else begin
                        hi_d = prod_s[2*WORD_LEN-1:WORD_LEN];
                        lo_d = prod_s[WORD_LEN-1:0];
                    end
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= {(2*WORD_LEN){1'b0}};
            opb_q     <= {WORD_LEN{1'b0}};
            hi_q      <= {WORD_LEN{1'b0}};
            lo_q      <= {WORD_LEN{1'b0}};
            count_q   <= {CW{1'b0}};
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            divz_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            divz_q    <= divz_d;
            done_q    <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign done  = done_q;
    assign busy  = (state_q != ST_IDLE);
    assign stall = busy & (mf_req | start);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit (default build and MULDIV_FAST_MULT_EN build).
module tb_hilo_muldiv_unit;
    localparam int W       = 32;
    localparam int DIV_LAT = W + 1;
`ifdef MULDIV_FAST_MULT_EN
    localparam int         MUL_LAT = 0;
    localparam logic [2:0] B2B_OP  = 3'b011;
    localparam logic [W-1:0] B2B_HI1 = 32'h00000000, B2B_LO1 = 32'h00000001;
    localparam logic [W-1:0] B2B_HI2 = 32'h00000003, B2B_LO2 = 32'h00000000;
`else
    localparam int         MUL_LAT = W + 1;
    localparam logic [2:0] B2B_OP  = 3'b001;
    localparam logic [W-1:0] B2B_HI1 = 32'hFFFFFFFE, B2B_LO1 = 32'h00000001;
    localparam logic [W-1:0] B2B_HI2 = 32'h00000000, B2B_LO2 = 32'h0000000F;
`endif

    logic         clock = 1'b0;
    logic         reset, start, mf_req, flush;
    logic [2:0]   md_op;
    logic [W-1:0] val1, val2, hi, lo;
    logic         busy, done, stall;
    int           n_vec = 0;
    int           n_err = 0;

    hilo_muldiv_unit #(.WORD_LEN(W)) dut (
        .clock(clock), .reset(reset), .start(start), .md_op(md_op),
        .val1(val1), .val2(val2), .mf_req(mf_req), .flush(flush),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clock = ~clock;

    // Presents one op for one edge, then counts the cycles busy stays high.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int cyc);
        start = 1'b1; md_op = op; val1 = a; val2 = b;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; mf_req = 1'b1; flush = 1'b0;
        md_op = 3'b010; val1 = 32'h5; val2 = 32'h3;
        repeat (2) @(posedge clock);
        #1;
        n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
        n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        start = 1'b0; mf_req = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_mult();
        int cyc;
        run_op(3'b000, 32'hFFFFFFFD, 32'h00000007, cyc);
        n_vec++; if (cyc !== MUL_LAT) begin n_err++; $display("FAIL mult_latency: got %0d want %0d", cyc, MUL_LAT); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL mult_done: got %b want 1", done); end
        n_vec++; if (hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi: got %h want %h", hi, 32'hFFFFFFFF); end
        n_vec++; if (lo !== 32'hFFFFFFEB) begin n_err++; $display("FAIL mult_lo: got %h want %h", lo, 32'hFFFFFFEB); end
        @(posedge clock); #1;
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mult_done_pulse: got %b want 0", done); end
        run_op(3'b000, 32'd6, 32'd7, cyc);
        n_vec++; if (lo !== 32'd42 || hi !== 32'd0) begin n_err++; $display("FAIL mult_6x7: got %h_%h want 00000000_0000002a", hi, lo); end
    endtask

    task automatic test_multu();
        int cyc;
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
        n_vec++; if (cyc !== MUL_LAT) begin n_err++; $display("FAIL multu_latency: got %0d want %0d", cyc, MUL_LAT); end
        n_vec++; if (hi !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_hi: got %h want %h", hi, 32'hFFFFFFFE); end
        n_vec++; if (lo !== 32'h00000001) begin n_err++; $display("FAIL multu_lo: got %h want %h", lo, 32'h00000001); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad;
        start = 1'b1; md_op = B2B_OP; val1 = 32'hFFFFFFFF; val2 = 32'hFFFFFFFF;
        @(posedge clock); #1;
        val1 = 32'd3; val2 = 32'd5;
        cyc = 0; bad = 0;
        while (busy === 1'b1 && cyc < 200) begin
            if (stall !== 1'b1) bad++;
            cyc++;
            @(posedge clock); #1;
        end
        n_vec++; if (cyc !== DIV_LAT) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", cyc, DIV_LAT); end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL b2b_stall_busy: got %0d low cycles want 0", bad); end
        n_vec++; if (done !== 1'b1 || stall !== 1'b0) begin n_err++; $display("FAIL b2b_done_cycle: got done=%b stall=%b want 1 0", done, stall); end
        n_vec++; if (hi !== B2B_HI1 || lo !== B2B_LO1) begin n_err++; $display("FAIL b2b_first: got %h_%h want %h_%h", hi, lo, B2B_HI1, B2B_LO1); end
        @(posedge clock); #1;
        n_vec++; if (busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept: got busy=%b done=%b want 1 0", busy, done); end
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin cyc++; @(posedge clock); #1; end
        n_vec++; if (hi !== B2B_HI2 || lo !== B2B_LO2) begin n_err++; $display("FAIL b2b_second: got %h_%h want %h_%h", hi, lo, B2B_HI2, B2B_LO2); end
    endtask

    task automatic test_div();
        int cyc;
        run_op(3'b010, 32'hFFFFFFF9, 32'd2, cyc);
        n_vec++; if (cyc !== DIV_LAT) begin n_err++; $display("FAIL div_latency: got %0d want %0d", cyc, DIV_LAT); end
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL div_done: got %b want 1", done); end
        n_vec++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_neg7_2: got %h_%h want ffffffff_fffffffd", hi, lo); end
        run_op(3'b011, 32'd7, 32'd2, cyc);
        n_vec++; if (lo !== 32'd3 || hi !== 32'd1) begin n_err++; $display("FAIL divu_7_2: got %h_%h want 00000001_00000003", hi, lo); end
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, cyc);
        n_vec++; if (lo !== 32'h80000000 || hi !== 32'h0) begin n_err++; $display("FAIL div_overflow: got %h_%h want 00000000_80000000", hi, lo); end
        run_op(3'b010, 32'd100, 32'hFFFFFFF9, cyc);
        n_vec++; if (lo !== 32'hFFFFFFF2 || hi !== 32'd2) begin n_err++; $display("FAIL div_100_neg7: got %h_%h want 00000002_fffffff2", hi, lo); end
    endtask

    task automatic test_divzero();
        int cyc;
        run_op(3'b011, 32'd7, 32'd0, cyc);
        n_vec++; if (cyc !== DIV_LAT) begin n_err++; $display("FAIL divu0_latency: got %0d want %0d", cyc, DIV_LAT); end
        n_vec++; if (lo !== 32'hFFFFFFFF || hi !== 32'd7) begin n_err++; $display("FAIL divu0_result: got %h_%h want 00000007_ffffffff", hi, lo); end
        run_op(3'b010, 32'hFFFFFFF9, 32'd0, cyc);
        n_vec++; if (cyc !== DIV_LAT) begin n_err++; $display("FAIL div0_latency: got %0d want %0d", cyc, DIV_LAT); end
        n_vec++; if (lo !== 32'hFFFFFFFF || hi !== 32'hFFFFFFF9) begin n_err++; $display("FAIL div0_result: got %h_%h want fffffff9_ffffffff", hi, lo); end
    endtask

    task automatic test_mf_flush();
        int cyc;
        int bad;
        int dseen;
        start = 1'b1; md_op = 3'b010; val1 = 32'd100; val2 = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        mf_req = 1'b1;
        #1;
        cyc = 0; bad = 0;
        while (busy === 1'b1 && cyc < 200) begin
            if (stall !== 1'b1) bad++;
            cyc++;
            @(posedge clock); #1;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL mf_stall_busy: got %0d low cycles want 0", bad); end
        n_vec++; if (cyc !== DIV_LAT - 2) begin n_err++; $display("FAIL mf_stall_len: got %0d want %0d", cyc, DIV_LAT - 2); end
        n_vec++; if (stall !== 1'b0 || done !== 1'b1) begin n_err++; $display("FAIL mf_done_cycle: got stall=%b done=%b want 0 1", stall, done); end
        n_vec++; if (lo !== 32'd14 || hi !== 32'd2) begin n_err++; $display("FAIL mf_result: got %h_%h want 00000002_0000000e", hi, lo); end
        mf_req = 1'b0;
        start = 1'b1; md_op = 3'b010; val1 = 32'd50; val2 = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_idle: got busy=%b want 0", busy); end
        dseen = (done === 1'b1) ? 1 : 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done === 1'b1) dseen++;
        end
        n_vec++; if (dseen !== 0) begin n_err++; $display("FAIL flush_no_done: got %0d pulses want 0", dseen); end
        n_vec++; if (lo !== 32'd14 || hi !== 32'd2) begin n_err++; $display("FAIL flush_hilo_kept: got %h_%h want 00000002_0000000e", hi, lo); end
        start = 1'b1; flush = 1'b1; md_op = 3'b010; val1 = 32'd9; val2 = 32'd3;
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_start_div: got busy=%b want 0", busy); end
        start = 1'b1; flush = 1'b1; md_op = 3'b100; val1 = 32'hDEADBEEF;
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0;
        n_vec++; if (hi !== 32'd2) begin n_err++; $display("FAIL flush_start_mthi: got %h want %h", hi, 32'd2); end
    endtask

    task automatic test_mt_and_illegal();
        int cyc;
        run_op(3'b100, 32'h12345678, 32'h0, cyc);
        n_vec++; if (hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mthi: got hi=%h busy=%b done=%b want 12345678 0 0", hi, busy, done); end
        run_op(3'b101, 32'h00000009, 32'h0, cyc);
        n_vec++; if (lo !== 32'h9 || hi !== 32'h12345678 || busy !== 1'b0) begin n_err++; $display("FAIL mtlo: got %h_%h busy=%b want 12345678_00000009 0", hi, lo, busy); end
        run_op(3'b110, 32'hAAAA5555, 32'h3, cyc);
        n_vec++; if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'h9) begin n_err++; $display("FAIL op110_noop: got %h_%h busy=%b want 12345678_00000009 0", hi, lo, busy); end
        run_op(3'b111, 32'hAAAA5555, 32'h3, cyc);
        n_vec++; if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'h9) begin n_err++; $display("FAIL op111_noop: got %h_%h busy=%b want 12345678_00000009 0", hi, lo, busy); end
    endtask

    task automatic test_reset_mid();
        int dseen;
        start = 1'b1; md_op = 3'b010; val1 = 32'd100; val2 = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        n_vec++; if (hi !== 32'h0 || lo !== 32'h0) begin n_err++; $display("FAIL rstmid_hilo: got %h_%h want 00000000_00000000", hi, lo); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        @(posedge clock); #1;
        reset = 1'b0;
        dseen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done === 1'b1 || busy === 1'b1) dseen++;
        end
        n_vec++; if (dseen !== 0) begin n_err++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", dseen); end
    endtask

`ifdef MULDIV_FAST_MULT_EN
    task automatic test_fast_mult();
        start = 1'b1; md_op = 3'b000; val1 = 32'd6; val2 = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        n_vec++; if (lo !== 32'd42 || hi !== 32'd0) begin n_err++; $display("FAIL fast_result: got %h_%h want 00000000_0000002a", hi, lo); end
        n_vec++; if (busy !== 1'b0 || done !== 1'b1) begin n_err++; $display("FAIL fast_flags: got busy=%b done=%b want 0 1", busy, done); end
        @(posedge clock); #1;
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL fast_done_pulse: got %b want 0", done); end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; mf_req = 1'b0; flush = 1'b0;
        md_op = 3'b000; val1 = 32'h0; val2 = 32'h0;
        test_reset();
        test_mult();
        test_multu();
        test_back_to_back();
        test_div();
        test_divzero();
        test_mf_flush();
        test_mt_and_illegal();
        test_reset_mid();
`ifdef MULDIV_FAST_MULT_EN
        test_fast_mult();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
